cap_current_model: RTL and testbench
====================================

CAP_CURRENT_MODEL -- requirements
Module: cap_current_model

Interface
REQ-001 Parameter GAIN_Q88, default 16'd256, meaning 2*C/TS as unsigned Q8.8, where 256 = 1.0.
REQ-002 Parameter I_W, default 24, meaning output current width in bits.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, reset: synchronous, active-high.
REQ-005 Port clr, input, 1, synchronous history clear while running.
REQ-006 Port s_valid, input, 1, voltage sample valid.
REQ-007 Port s_ready, output, 1, block accepts a voltage sample.
REQ-008 Port s_vin, input, 16 signed, voltage sample v[n] in integer LSB units.
REQ-009 Port m_valid, output, 1, current sample valid.
REQ-010 Port m_ready, input, 1, downstream accepts the current sample.
REQ-011 Port m_iout, output, I_W signed, current sample i[n].
REQ-012 Port ovf, output, 1, sticky saturation flag.

Function
REQ-013 The block SHALL compute the trapezoidal inverse capacitor model: i[n] = ((GAIN_Q88 * (v[n] - v[n-1])) >>> 8) - i[n-1].
REQ-014 The difference dv SHALL be 17-bit signed with no wrap, and the product SHALL be 33-bit signed.
REQ-015 The shift SHALL be arithmetic, truncating toward negative infinity.
REQ-016 The subtraction SHALL be carried at I_W+10 bits.
REQ-017 The result SHALL saturate to [-2^(I_W-1), 2^(I_W-1)-1].
REQ-018 On saturation ovf SHALL be set and held until rst.
REQ-019 The stored i[n-1] SHALL be the saturated value.
REQ-020 The FSM states SHALL be IDLE, CALC and HOLD.
REQ-021 IDLE: s_ready=1; on s_valid the block SHALL capture s_vin, register dv = s_vin - v_prev, and go to CALC.
REQ-022 CALC: s_ready=0; the block SHALL compute the product, shift, subtract and saturate, load m_iout, update v_prev and i_prev, assert m_valid, and go to HOLD.
REQ-023 HOLD: m_valid=1 and m_iout SHALL stay stable; on m_ready the block SHALL go to IDLE with m_valid=0 on the next cycle.
REQ-024 Latency SHALL be: sample accepted at edge N, m_valid high after edge N+1.
REQ-025 Throughput SHALL be one sample per 3 cycles when m_ready is held high.
REQ-026 s_ready SHALL be a pure decode of state==IDLE, never combinationally dependent on m_ready.
REQ-027 The first sample after rst or clr SHALL use v_prev=0 and i_prev=0.
REQ-028 clr in IDLE SHALL zero v_prev and i_prev; no sample is accepted that cycle.
REQ-029 clr in CALC SHALL abort: no output is produced, history is zeroed, and the FSM goes to IDLE.
REQ-030 clr in HOLD SHALL zero history, leave m_valid and m_iout unchanged, and complete the handshake normally.
REQ-031 clr SHALL not clear ovf.
REQ-032 When rst and clr are both high, rst SHALL take priority.

Reset
REQ-033 On rst the FSM SHALL go to IDLE.
REQ-034 On rst, m_valid=0, m_iout=0, ovf=0, v_prev=0, i_prev=0 and the dv register=0.
REQ-035 s_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-036 rst mid-operation SHALL discard any in-flight or held sample with no output handshake.

Structure
REQ-037 Package cap_model_pkg SHALL hold the FSM state enum, V_W=16, DV_W=17, FRAC_Q=8 and the saturation helper function.
REQ-038 Sub-module cap_diff_datapath SHALL contain the combinational multiply, shift, subtract and saturate (inputs dv, i_prev; outputs i_next, sat).
REQ-039 The FSM and all registers SHALL stay in cap_current_model.

Verification
REQ-040 Scenario, unity gain: GAIN=256, m_ready=1, vin 0,100,100,100 -> iout 0,100,-100,100.
REQ-041 Scenario, latency: accept at edge N -> m_valid high after N+1; s_ready low for exactly 2 cycles.
REQ-042 Scenario, backpressure: m_ready=0 for 5 cycles in HOLD -> m_iout stable, s_ready=0; first m_ready cycle completes the handshake.
REQ-043 Scenario, saturation: GAIN=16'hFFFF, vin -32768 then 32767 -> iout 8388607, ovf=1 and held; next equal vin -> iout -8388607.
REQ-044 Scenario, clr: vin 100 then 200 with clr pulsed in CALC -> no output for the aborted sample; next vin 50 -> iout 50.
REQ-045 Scenario, reset: rst during HOLD -> m_valid=0 next cycle, all outputs zero, ovf=0, next vin 10 -> iout 10.

Source files
------------

// File: rtl/cap_model_pkg.sv
// Shared types, widths and the saturation helper for the trapezoidal
// inverse-capacitor current model.
package cap_model_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int V_W    = 16;
  localparam int DV_W   = 17;
  localparam int FRAC_Q = 8;
  localparam int PROD_W = 33;

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x,
                                                   input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      r = hi;
    end else if (x < lo) begin
      r = lo;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/cap_diff_datapath.sv
// Combinational core: i_next = sat(((GAIN * dv) >>> 8) - i_prev).
module cap_diff_datapath
  import cap_model_pkg::*;
#(
  parameter logic [15:0] GAIN_Q88 = 16'd256,
  parameter int          I_W      = 24
) (
  input  logic signed [DV_W-1:0] dv,
  input  logic signed [I_W-1:0]  i_prev,
  output logic signed [I_W-1:0]  i_next,
  output logic                   sat
);

  localparam int SUM_W = I_W + 10;

  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] dv_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic signed [SUM_W-1:0]  diff;
  logic signed [63:0]       diff_wide;
  logic signed [63:0]       clamped;

  // Gain is unsigned, so it enters the signed multiply zero-extended.
  always_comb begin
    gain_ext  = $signed({{(PROD_W-16){1'b0}}, GAIN_Q88});
    dv_ext    = PROD_W'(dv);
    prod      = gain_ext * dv_ext;
    shifted   = prod >>> FRAC_Q;
    diff      = SUM_W'(shifted) - SUM_W'(i_prev);
    diff_wide = 64'(diff);
    clamped   = sat_clamp(diff_wide, I_W);
    i_next    = I_W'(clamped);
    sat       = (clamped != diff_wide);
  end

endmodule

// File: rtl/cap_current_model.sv
// Trapezoidal inverse-capacitor model: one voltage sample in, one current
// sample out, with IDLE/CALC/HOLD sequencing and sticky overflow.
module cap_current_model
  import cap_model_pkg::*;
#(
  parameter logic [15:0] GAIN_Q88 = 16'd256,
  parameter int          I_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic signed [V_W-1:0] s_vin,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic signed [I_W-1:0] m_iout,
  output logic                  ovf
);

  state_e                 state_q;
  logic signed [V_W-1:0]  v_prev_q;
  logic signed [V_W-1:0]  v_cur_q;
  logic signed [DV_W-1:0] dv_q;
  logic signed [I_W-1:0]  i_prev_q;
  logic signed [I_W-1:0]  m_iout_q;
  logic                   m_valid_q;
  logic                   ovf_q;
  logic signed [I_W-1:0]  i_d;
  logic                   sat_d;

  cap_diff_datapath #(
    .GAIN_Q88(GAIN_Q88),
    .I_W     (I_W)
  ) u_dp (
    .dv    (dv_q),
    .i_prev(i_prev_q),
    .i_next(i_d),
    .sat   (sat_d)
  );

  // Sequencer and all state; clr only touches history, never ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      v_prev_q  <= '0;
      v_cur_q   <= '0;
      dv_q      <= '0;
      i_prev_q  <= '0;
      m_iout_q  <= '0;
      m_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            v_prev_q <= '0;
            i_prev_q <= '0;
          end else if (s_valid) begin
            v_cur_q <= s_vin;
            dv_q    <= DV_W'(s_vin) - DV_W'(v_prev_q);
            state_q <= CALC;
          end
        end
        CALC: begin
          if (clr) begin
            v_prev_q <= '0;
            i_prev_q <= '0;
            state_q  <= IDLE;
          end else begin
            m_iout_q  <= i_d;
            i_prev_q  <= i_d;
            v_prev_q  <= v_cur_q;
            m_valid_q <= 1'b1;
            ovf_q     <= ovf_q | sat_d;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (clr) begin
            v_prev_q <= '0;
            i_prev_q <= '0;
          end
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = (state_q == IDLE);
  assign m_valid = m_valid_q;
  assign m_iout  = m_iout_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_cap_current_model.sv
// Scoreboard bench for cap_current_model: unity-gain and max-gain instances.
module tb_cap_current_model;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clr = 1'b0;
  logic               m_ready = 1'b1;
  logic               s_valid = 1'b0;
  logic signed [15:0] s_vin = '0;
  logic               s_ready;
  logic               m_valid;
  logic signed [23:0] m_iout;
  logic               ovf;
  logic               sat_s_valid = 1'b0;
  logic signed [15:0] sat_s_vin = '0;
  logic               sat_s_ready;
  logic               sat_m_valid;
  logic signed [23:0] sat_m_iout;
  logic               sat_ovf;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic signed [23:0] exp_q[$];
  logic signed [23:0] sat_q[$];

  always #5 clk = ~clk;

  cap_current_model #(.GAIN_Q88(16'd256), .I_W(24)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(s_ready),
    .s_vin(s_vin), .m_valid(m_valid), .m_ready(m_ready), .m_iout(m_iout), .ovf(ovf)
  );

  cap_current_model #(.GAIN_Q88(16'hFFFF), .I_W(24)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(sat_s_valid), .s_ready(sat_s_ready),
    .s_vin(sat_s_vin), .m_valid(sat_m_valid), .m_ready(m_ready), .m_iout(sat_m_iout),
    .ovf(sat_ovf)
  );

  // Scoreboard for the unity-gain instance.
  always @(negedge clk) begin
    if (m_valid && m_ready && !rst) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL iout_unexpected: got %0d, required no output", m_iout);
      end else begin
        logic signed [23:0] e;
        e = exp_q.pop_front();
        if (m_iout !== e) $display("FAIL iout: got %0d, required %0d", m_iout, e);
        else pass_cnt++;
      end
    end
  end

  // Scoreboard for the max-gain instance.
  always @(negedge clk) begin
    if (sat_m_valid && m_ready && !rst) begin
      chk_cnt++;
      if (sat_q.size() == 0) begin
        $display("FAIL sat_iout_unexpected: got %0d, required no output", sat_m_iout);
      end else begin
        logic signed [23:0] e;
        e = sat_q.pop_front();
        if (sat_m_iout !== e) $display("FAIL sat_iout: got %0d, required %0d", sat_m_iout, e);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit sel, input logic signed [15:0] v,
                       input logic signed [23:0] e, input bit expect_out);
    int n;
    n = 0;
    @(negedge clk);
    while (!(sel ? sat_s_ready : s_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk_cnt++;
      $display("FAIL s_ready_timeout: got 0 after %0d cycles, required 1", n);
    end
    if (expect_out) begin
      if (sel) sat_q.push_back(e);
      else exp_q.push_back(e);
    end
    if (sel) begin
      sat_s_valid = 1'b1;
      sat_s_vin   = v;
    end else begin
      s_valid = 1'b1;
      s_vin   = v;
    end
    @(posedge clk);
    #1;
    s_valid     = 1'b0;
    sat_s_valid = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int n;
    n = 0;
    while (((sel ? sat_q.size() : exp_q.size()) != 0 || (sel ? sat_m_valid : m_valid)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk_cnt++;
      $display("FAIL drain_timeout: %0d outputs still pending, required 0",
               sel ? sat_q.size() : exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({m_valid, ovf, s_ready} !== 3'b001 || m_iout !== 24'sd0)
      $display("FAIL reset_state: got valid=%b ovf=%b ready=%b iout=%0d, required 0 0 1 0",
               m_valid, ovf, s_ready, m_iout);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (s_ready !== 1'b1) $display("FAIL ready_after_reset: got %b, required 1", s_ready);
    else pass_cnt++;
  endtask

  task automatic test_unity();
    m_ready = 1'b1;
    drive(1'b0, 16'sd0,   24'sd0,    1'b1);
    drive(1'b0, 16'sd100, 24'sd100,  1'b1);
    drive(1'b0, 16'sd100, -24'sd100, 1'b1);
    drive(1'b0, 16'sd100, 24'sd100,  1'b1);
    drain(1'b0);
  endtask

  task automatic test_latency();
    drive(1'b0, 16'sd100, -24'sd100, 1'b1);
    @(negedge clk);
    chk_cnt++;
    if ({m_valid, s_ready} !== 2'b00)
      $display("FAIL latency_calc: got valid=%b ready=%b, required 0 0", m_valid, s_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({m_valid, s_ready} !== 2'b10)
      $display("FAIL latency_hold: got valid=%b ready=%b, required 1 0", m_valid, s_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({m_valid, s_ready} !== 2'b01)
      $display("FAIL latency_idle: got valid=%b ready=%b, required 0 1", m_valid, s_ready);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    drive(1'b0, 16'sd300, 24'sd300, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_iout !== 24'sd300)
        $display("FAIL backpressure_hold: got valid=%b ready=%b iout=%0d, required 1 0 300",
                 m_valid, s_ready, m_iout);
      else pass_cnt++;
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({m_valid, s_ready} !== 2'b01)
      $display("FAIL backpressure_release: got valid=%b ready=%b, required 0 1", m_valid, s_ready);
    else pass_cnt++;
  endtask

  task automatic test_clr();
    @(posedge clk);
    #1;
    clr = 1'b1;
    s_valid = 1'b1;
    s_vin = 16'sd777;
    @(posedge clk);
    #1;
    clr = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({m_valid, s_ready} !== 2'b01)
      $display("FAIL clr_idle_no_accept: got valid=%b ready=%b, required 0 1", m_valid, s_ready);
    else pass_cnt++;
    drive(1'b0, 16'sd100, 24'sd100, 1'b1);
    drain(1'b0);
    drive(1'b0, 16'sd200, 24'sd0, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({m_valid, s_ready} !== 2'b01)
      $display("FAIL clr_abort: got valid=%b ready=%b, required 0 1", m_valid, s_ready);
    else pass_cnt++;
    drive(1'b0, 16'sd50, 24'sd50, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    m_ready = 1'b0;
    drive(1'b0, 16'sd20, 24'sd0, 1'b0);
    n = 0;
    while (!m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (m_valid !== 1'b1) $display("FAIL reset_mid_hold: got valid=%b, required 1", m_valid);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({m_valid, ovf, s_ready} !== 3'b001 || m_iout !== 24'sd0)
      $display("FAIL reset_mid_state: got valid=%b ovf=%b ready=%b iout=%0d, required 0 0 1 0",
               m_valid, ovf, s_ready, m_iout);
    else pass_cnt++;
    m_ready = 1'b1;
    drive(1'b0, 16'sd10, 24'sd10, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_saturation();
    m_ready = 1'b1;
    chk_cnt++;
    if (sat_ovf !== 1'b0) $display("FAIL sat_ovf_initial: got %b, required 0", sat_ovf);
    else pass_cnt++;
    drive(1'b1, -16'sd32768, -24'sd8388480, 1'b1);
    drive(1'b1, 16'sd32767,  24'sd8388607,  1'b1);
    drain(1'b1);
    chk_cnt++;
    if (sat_ovf !== 1'b1) $display("FAIL sat_ovf_set: got %b, required 1", sat_ovf);
    else pass_cnt++;
    drive(1'b1, 16'sd32767, -24'sd8388607, 1'b1);
    drain(1'b1);
    chk_cnt++;
    if (sat_ovf !== 1'b1) $display("FAIL sat_ovf_held: got %b, required 1", sat_ovf);
    else pass_cnt++;
    chk_cnt++;
    if (ovf !== 1'b0) $display("FAIL unity_ovf_clear: got %b, required 0", ovf);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_unity();
    test_latency();
    test_backpressure();
    test_clr();
    test_reset_mid();
    test_saturation();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
